nv_fifo_ctrl_rwsthp_60x21: RTL



---
 rtl/nv_fifo_ctrl_rwsthp_60x21.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nv_fifo_ctrl_rwsthp_60x21.sv
// nv_fifo_ctrl_rwsthp_60x21
// FIFO controller for an external 60x21 nv_ram_rwsthp_60x21 instance. It owns
// the RAM write port and schedules reads through the RAM's two-stage read
// path (address register = stage 1, output register = FIFO output register).
// Optional feature macro: FIFO_BYPASS_EN -- when defined, a write into a
// completely empty FIFO skips the RAM array and lands in the output register
// through the RAM bypass mux (1-cycle latency instead of 3).
module nv_fifo_ctrl_rwsthp_60x21 (
   input  logic        nvdla_core_clk,
   input  logic        nvdla_core_rstn,
   input  logic        wr_pvld,
   output logic        wr_prdy,
   input  logic [20:0] wr_pd,
   output logic        rd_pvld,
   input  logic        rd_prdy,
   output logic [20:0] rd_pd,
   output logic [5:0]  ram_wa,
   output logic        ram_we,
   output logic [20:0] ram_di,
   output logic [5:0]  ram_ra,
   output logic        ram_re,
   output logic        ram_ore,
   output logic        ram_byp_sel,
   output logic [20:0] ram_dbyp,
   input  logic [20:0] ram_dout,
   output logic        idle
);

   localparam logic [5:0] DEPTH    = 6'd60;
   localparam logic [5:0] LAST_IDX = 6'd59;

   // occ_q counts entries written to the RAM array that have not yet been
   // loaded into the output register (the stage-1 entry is included).
   logic [5:0] wr_ptr_q, wr_ptr_d;
   logic [5:0] rd_ptr_q, rd_ptr_d;
   logic [5:0] occ_q, occ_d;
   logic       s1_vld_q, s1_vld_d;
   logic       out_vld_q, out_vld_d;

   logic       wr_acc;
   logic       out_adv;
   logic       byp;
   logic       ore_s1;

   // Handshake and RAM port control, all derived from current state.
   always_comb begin
      wr_prdy = (occ_q != DEPTH);
      wr_acc  = wr_pvld & wr_prdy;
      // The output register may be (re)loaded when empty or being consumed.
      out_adv = ~out_vld_q | rd_prdy;
`ifdef FIFO_BYPASS_EN
      // Nothing older anywhere in the pipe: the write can go straight to the
      // output register without touching the array.
      byp = wr_acc & (occ_q == 6'd0) & ~s1_vld_q & out_adv;
`else
      byp = 1'b0;
`endif
      ore_s1 = s1_vld_q & out_adv;

      ram_we  = wr_acc & ~byp;
      ram_wa  = wr_ptr_q;
      ram_di  = wr_pd;
      ram_ore = ore_s1 | byp;
      // Fetch a new entry into stage 1 when there is one in the array beyond
      // the stage-1 entry and stage 1 is empty or moving on this cycle.
      ram_re  = (occ_q != {5'd0, s1_vld_q}) & (~s1_vld_q | ram_ore);
      ram_ra  = rd_ptr_q;

`ifdef FIFO_BYPASS_EN
      ram_byp_sel = byp;
      ram_dbyp    = byp ? wr_pd : 21'd0;
`else
      ram_byp_sel = 1'b0;
      ram_dbyp    = 21'd0;
`endif

      rd_pvld = out_vld_q;
      rd_pd   = ram_dout;
      idle    = (occ_q == 6'd0) & ~s1_vld_q & ~out_vld_q;
   end

   // Next-state computation for pointers, occupancy and the two valid flags.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      s1_vld_d  = s1_vld_q;
      out_vld_d = out_vld_q;

      if (ram_we) begin
         wr_ptr_d = (wr_ptr_q == LAST_IDX) ? 6'd0 : wr_ptr_q + 6'd1;
      end

      if (ram_re) begin
         rd_ptr_d = (rd_ptr_q == LAST_IDX) ? 6'd0 : rd_ptr_q + 6'd1;
      end

      // A write and a stage-1 -> output move in the same cycle cancel out.
      case ({ram_we, ore_s1})
         2'b10:   occ_d = occ_q + 6'd1;
         2'b01:   occ_d = occ_q - 6'd1;
         default: occ_d = occ_q;
      endcase

      if (ram_re) begin
         s1_vld_d = 1'b1;
      end else if (ore_s1) begin
         s1_vld_d = 1'b0;
      end

      if (ram_ore) begin
         out_vld_d = 1'b1;
      end else if (rd_prdy) begin
         out_vld_d = 1'b0;
      end
   end

   // State registers; reset discards all queued contents immediately.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         wr_ptr_q  <= 6'd0;
         rd_ptr_q  <= 6'd0;
         occ_q     <= 6'd0;
         s1_vld_q  <= 1'b0;
         out_vld_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         s1_vld_q  <= s1_vld_d;
         out_vld_q <= out_vld_d;
      end
   end

endmodule
